// File: rtl/gshare_branch_predictor.sv
// gshare_branch_predictor: gshare direction predictor with an in-order resolve queue,
// registered redirect on mispredict, history repair and performance counters.
module gshare_branch_predictor #(
    parameter int IDX_W  = 4,
    parameter int HIST_W = 4,
    parameter int CNT_W  = 2,
    parameter int Q_W    = 3
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        pred_valid,
    input  logic [31:0] pred_pc,
    input  logic [31:0] pred_imm,
    output logic        pred_ready,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        res_valid,
    input  logic [31:0] res_addr,
    input  logic        res_taken,
    output logic        mispredict,
    output logic [31:0] fail_addr,
    output logic [31:0] resolved_cnt,
    output logic [31:0] mispred_cnt
);
    localparam int DEPTH = 1 << Q_W;
    typedef struct packed {
        logic [31:0]       pc;
        logic [IDX_W-1:0]  idx;
        logic              pred;
        logic [31:0]       alt;
        logic [HIST_W-1:0] snap;
    } entry_t;
    logic [CNT_W-1:0]  ctr_q [2**IDX_W];
    entry_t            q_q [DEPTH];
    logic [HIST_W-1:0] hist_q, hist_d;
    logic [Q_W-1:0]    front_q, rear_q;
    logic [Q_W:0]      count_q, count_d;
    logic              mispredict_q;
    logic [31:0]       fail_addr_q, resolved_q, mispred_cnt_q;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  ctr_h, ctr_d;
    logic              resolve, mis, push;
    entry_t            head, new_e;
    logic              unused_pc;
    assign unused_pc = &{1'b0, pred_pc[31:IDX_W+2], pred_pc[1:0]};
    always_comb begin
        idx         = pred_pc[IDX_W+1:2] ^ IDX_W'(hist_q);
        pred_taken  = pred_valid & ctr_q[idx][CNT_W-1];
        pred_target = pred_taken ? pred_pc + pred_imm : pred_pc + 32'd4;
        pred_ready  = count_q != (Q_W+1)'(DEPTH);
        head        = q_q[front_q];
        resolve     = rdy_in && res_valid && count_q != '0 && res_addr == head.pc;
        mis         = resolve && head.pred != res_taken;
        push        = rdy_in && pred_valid && pred_ready && !mis;
        ctr_h       = ctr_q[head.idx];
        ctr_d       = res_taken ? (&ctr_h ? ctr_h : ctr_h + 1'b1) : (|ctr_h ? ctr_h - 1'b1 : ctr_h);
        new_e       = '{pc: pred_pc, idx: idx, pred: pred_taken,
                        alt: pred_taken ? pred_pc + 32'd4 : pred_pc + pred_imm, snap: hist_q};
        hist_d      = mis ? HIST_W'({head.snap, res_taken}) : push ? HIST_W'({hist_q, pred_taken}) : hist_q;
        count_d     = mis ? '0 : count_q + (Q_W+1)'(push) - (Q_W+1)'(resolve);
        mispredict   = mispredict_q;
        fail_addr    = fail_addr_q;
        resolved_cnt = resolved_q;
        mispred_cnt  = mispred_cnt_q;
    end
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < 2**IDX_W; i++) ctr_q[i] <= CNT_W'((1 << (CNT_W-1)) - 1);
            hist_q        <= '0;
            front_q       <= '0;
            rear_q        <= '0;
            count_q       <= '0;
            mispredict_q  <= 1'b0;
            fail_addr_q   <= '0;
            resolved_q    <= '0;
            mispred_cnt_q <= '0;
        end else if (rdy_in) begin
            if (resolve) ctr_q[head.idx] <= ctr_d;
            hist_q        <= hist_d;
            count_q       <= count_d;
            front_q       <= mis ? '0 : front_q + Q_W'(resolve);
            rear_q        <= mis ? '0 : rear_q + Q_W'(push);
            mispredict_q  <= mis;
            fail_addr_q   <= mis ? head.alt : '0;
            resolved_q    <= resolved_q + 32'(resolve);
            mispred_cnt_q <= mispred_cnt_q + 32'(mis);
        end
    end
    // Payload storage needs no reset: entries are only read while count is non-zero.
    always_ff @(posedge clk_in) begin
        if (push) q_q[rear_q] <= new_e;
    end
endmodule

// File: tb/tb_gshare_branch_predictor.sv
// tb_gshare_branch_predictor: randomized and directed checks against a queue-based
// behavioural model of the gshare predictor.
module tb_gshare_branch_predictor;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, pred_valid, res_valid, res_taken;
    logic [31:0] pred_pc, pred_imm, res_addr;
    logic        pred_ready, pred_taken, mispredict;
    logic [31:0] pred_target, fail_addr, resolved_cnt, mispred_cnt;
    int errors = 0;
    int checks = 0;

    gshare_branch_predictor dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_imm(pred_imm),
        .pred_ready(pred_ready), .pred_taken(pred_taken), .pred_target(pred_target),
        .res_valid(res_valid), .res_addr(res_addr), .res_taken(res_taken),
        .mispredict(mispredict), .fail_addr(fail_addr),
        .resolved_cnt(resolved_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] pc;
        int          idx;
        bit          pred;
        logic [31:0] alt;
        int          snap;
    } ent_t;
    int          ctr [16];
    int          hist;
    ent_t        mq [$];
    bit          e_mis;
    logic [31:0] e_fail, e_res, e_misc;

    function automatic int m_idx();
        return int'((pred_pc >> 2) & 32'hf) ^ hist;
    endfunction

    function automatic bit m_taken();
        return pred_valid && ctr[m_idx()] >= 2;
    endfunction

    function automatic logic [31:0] m_target();
        return m_taken() ? pred_pc + pred_imm : pred_pc + 32'd4;
    endfunction

    task automatic model_step();
        int   i;
        bit   t, res, mis, psh;
        ent_t e;
        if (rst_in) begin
            foreach (ctr[k]) ctr[k] = 1;
            hist = 0;
            mq.delete();
            e_mis = 0; e_fail = 0; e_res = 0; e_misc = 0;
        end else if (rdy_in) begin
            i = m_idx();
            t = m_taken();
            res = res_valid && mq.size() > 0 && res_addr == mq[0].pc;
            mis = res && mq[0].pred != res_taken;
            psh = pred_valid && mq.size() < 8 && !mis;
            e_mis = mis;
            e_fail = mis ? mq[0].alt : 32'd0;
            if (res) begin
                if (res_taken) ctr[mq[0].idx] = ctr[mq[0].idx] < 3 ? ctr[mq[0].idx] + 1 : 3;
                else ctr[mq[0].idx] = ctr[mq[0].idx] > 0 ? ctr[mq[0].idx] - 1 : 0;
                e_res++;
            end
            if (mis) begin
                e_misc++;
                hist = (mq[0].snap * 2 + int'(res_taken)) % 16;
                mq.delete();
            end else begin
                if (res) void'(mq.pop_front());
                if (psh) begin
                    e.pc = pred_pc; e.idx = i; e.pred = t; e.snap = hist;
                    e.alt = t ? pred_pc + 32'd4 : pred_pc + pred_imm;
                    mq.push_back(e);
                    hist = (hist * 2 + int'(t)) % 16;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        model_step();
        #1;
    endtask

    task automatic drive(input bit pv, input logic [31:0] pc, input logic [31:0] imm,
                         input bit rv, input logic [31:0] ra, input bit rt);
        pred_valid = pv; pred_pc = pc; pred_imm = imm;
        res_valid = rv; res_addr = ra; res_taken = rt;
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1; rdy_in = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        rst_in = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (pred_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", pred_ready); end
        checks++;
        if ({mispredict, fail_addr} !== 33'd0) begin errors++; $display("FAIL reset_redirect got=%b/%h want=0/0", mispredict, fail_addr); end
        checks++;
        if ({resolved_cnt, mispred_cnt} !== 64'd0) begin errors++; $display("FAIL reset_perf got=%0d/%0d want=0/0", resolved_cnt, mispred_cnt); end
    endtask

    task automatic test_train();
        logic [31:0] pc;
        do_reset();
        drive(1, 32'h100, 32'h40, 0, 0, 0);
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
            errors++; $display("FAIL first_pred got=%b/%h want=0/00000104", pred_taken, pred_target);
        end
        tick();
        drive(0, 0, 0, 1, 32'h100, 1);
        tick();
        checks++;
        if (mispredict !== 1'b1 || fail_addr !== 32'h140 || mispred_cnt !== 32'd1) begin
            errors++; $display("FAIL first_mispredict got=%b/%h/%0d want=1/00000140/1", mispredict, fail_addr, mispred_cnt);
        end
        for (int r = 0; r < 2; r++) begin
            pc = 32'h100 | (32'(hist) << 2);
            drive(1, pc, 32'h40, 0, 0, 0);
            checks++;
            if (pred_taken !== m_taken() || pred_target !== m_target()) begin
                errors++; $display("FAIL train_pred got=%b/%h want=%b/%h", pred_taken, pred_target, m_taken(), m_target());
            end
            tick();
            drive(0, 0, 0, 1, pc, 1);
            tick();
            checks++;
            if (mispredict !== e_mis || resolved_cnt !== e_res) begin
                errors++; $display("FAIL train_resolve got=%b/%0d want=%b/%0d", mispredict, resolved_cnt, e_mis, e_res);
            end
        end
        pc = 32'h100 | (32'(hist) << 2);
        drive(1, pc, 32'h40, 0, 0, 0);
        checks++;
        if (pred_taken !== 1'b1 || pred_target !== pc + 32'h40) begin
            errors++; $display("FAIL trained_pred got=%b/%h want=1/%h", pred_taken, pred_target, pc + 32'h40);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1, 32'h1000 + 32'(i * 4), 32'h8, 0, 0, 0);
            tick();
        end
        drive(1, 32'h2000, 32'h8, 0, 0, 0);
        checks++;
        if (pred_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b want=0", pred_ready); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (pred_ready !== 1'b0) begin errors++; $display("FAIL full_no_push got=%b want=0", pred_ready); end
        drive(0, 0, 0, 1, mq[0].pc, mq[0].pred);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (pred_ready !== 1'b1 || mispredict !== 1'b0 || resolved_cnt !== 32'd1) begin
            errors++; $display("FAIL full_drain got=%b/%b/%0d want=1/0/1", pred_ready, mispredict, resolved_cnt);
        end
    endtask

    task automatic test_back_to_back_flush();
        logic [31:0] alt;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h300 + 32'(i * 4), 32'($urandom_range(1, 255)) << 2, 0, 0, 0);
            tick();
        end
        alt = mq[0].alt;
        drive(1, 32'h400, 32'h10, 1, mq[0].pc, !mq[0].pred);
        tick();
        checks++;
        if (mispredict !== 1'b1 || fail_addr !== alt) begin
            errors++; $display("FAIL flush_redirect got=%b/%h want=1/%h", mispredict, fail_addr, alt);
        end
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (pred_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got=%b want=1", pred_ready); end
        tick();
        checks++;
        if (mispredict !== 1'b0 || fail_addr !== 32'd0) begin
            errors++; $display("FAIL flush_pulse got=%b/%h want=0/0", mispredict, fail_addr);
        end
        drive(0, 0, 0, 1, 32'h400, 1);
        tick();
        checks++;
        if (resolved_cnt !== e_res) begin errors++; $display("FAIL flush_dropped got=%0d want=%0d", resolved_cnt, e_res); end
        for (int i = 0; i < 16; i++) begin
            drive(1, 32'(i) << 2, 32'h20, 0, 0, 0);
            checks++;
            if (pred_taken !== m_taken()) begin
                errors++; $display("FAIL flush_history idx=%0d got=%b want=%b", i, pred_taken, m_taken());
            end
        end
    endtask

    task automatic test_ignore();
        do_reset();
        drive(1, 32'h100, 32'h40, 0, 0, 0);
        tick();
        drive(0, 0, 0, 1, 32'h200, 1);
        tick();
        checks++;
        if (resolved_cnt !== 32'd0 || mispredict !== 1'b0) begin
            errors++; $display("FAIL ignore_addr got=%0d/%b want=0/0", resolved_cnt, mispredict);
        end
        rdy_in = 1'b0;
        drive(0, 0, 0, 1, 32'h100, 1);
        tick();
        checks++;
        if (resolved_cnt !== 32'd0 || mispredict !== 1'b0) begin
            errors++; $display("FAIL ignore_rdy got=%0d/%b want=0/0", resolved_cnt, mispredict);
        end
        rdy_in = 1'b1;
        tick();
        checks++;
        if (resolved_cnt !== 32'd1 || mispredict !== 1'b1 || fail_addr !== 32'h140) begin
            errors++; $display("FAIL resume_rdy got=%0d/%b/%h want=1/1/00000140", resolved_cnt, mispredict, fail_addr);
        end
        rdy_in = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        checks++;
        if (mispredict !== 1'b1 || fail_addr !== 32'h140) begin
            errors++; $display("FAIL hold_rdy got=%b/%h want=1/00000140", mispredict, fail_addr);
        end
        rdy_in = 1'b1;
        tick();
        checks++;
        if (mispredict !== 1'b0) begin errors++; $display("FAIL hold_release got=%b want=0", mispredict); end
    endtask

    task automatic test_saturate();
        logic [31:0] pc;
        do_reset();
        for (int r = 0; r < 10; r++) begin
            pc = 32'h800 | (32'((5 ^ hist) & 15) << 2);
            drive(1, pc, 32'h40, 0, 0, 0);
            checks++;
            if (pred_taken !== m_taken()) begin
                errors++; $display("FAIL sat_pred round=%0d got=%b want=%b", r, pred_taken, m_taken());
            end
            tick();
            drive(0, 0, 0, 1, pc, r < 5);
            tick();
            checks++;
            if (mispredict !== e_mis) begin
                errors++; $display("FAIL sat_resolve round=%0d got=%b want=%b", r, mispredict, e_mis);
            end
            if (r == 5) begin
                drive(1, 32'h800 | (32'((5 ^ hist) & 15) << 2), 32'h40, 0, 0, 0);
                checks++;
                if (pred_taken !== 1'b1) begin errors++; $display("FAIL sat_top got=%b want=1", pred_taken); end
            end
        end
        drive(1, 32'h900, 32'h4, 0, 0, 0);
        tick();
        rst_in = 1'b1;
        drive(1, 32'h904, 32'h4, 1, 32'h900, 1);
        tick();
        rst_in = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (pred_ready !== 1'b1 || mispredict !== 1'b0 || resolved_cnt !== 32'd0) begin
            errors++; $display("FAIL mid_reset got=%b/%b/%0d want=1/0/0", pred_ready, mispredict, resolved_cnt);
        end
        for (int i = 0; i < 16; i++) begin
            drive(1, 32'(i) << 2, 32'h40, 0, 0, 0);
            checks++;
            if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_table idx=%0d got=%b want=0", i, pred_taken); end
        end
    endtask

    task automatic test_random();
        logic [31:0] ra;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rdy_in = ($urandom % 8) != 0;
            rst_in = ($urandom % 200) == 0;
            ra = (mq.size() > 0 && ($urandom % 4) != 0) ? mq[0].pc : 32'h100 + 32'($urandom % 32) * 4;
            drive($urandom % 2, 32'h100 + 32'($urandom % 32) * 4, $urandom & 32'hfffc,
                  $urandom % 2, ra, $urandom % 2);
            checks++;
            if (pred_taken !== m_taken() || pred_target !== m_target() || pred_ready !== (mq.size() < 8)) begin
                errors++; $display("FAIL rand_comb n=%0d got=%b/%h/%b want=%b/%h/%b", n, pred_taken, pred_target,
                                   pred_ready, m_taken(), m_target(), mq.size() < 8);
            end
            tick();
            checks++;
            if (mispredict !== e_mis || fail_addr !== e_fail || resolved_cnt !== e_res || mispred_cnt !== e_misc) begin
                errors++; $display("FAIL rand_reg n=%0d got=%b/%h/%0d/%0d want=%b/%h/%0d/%0d", n, mispredict, fail_addr,
                                   resolved_cnt, mispred_cnt, e_mis, e_fail, e_res, e_misc);
            end
        end
        rst_in = 1'b0;
        rdy_in = 1'b1;
    endtask

    initial begin
        test_reset();
        test_train();
        test_full();
        test_back_to_back_flush();
        test_ignore();
        test_saturate();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
